// File: rtl/imm_ext_if.sv
// Immediate-extension stream bundle.
//   master : producer/consumer side; drives in_valid/in_imm/in_mode/out_ready
//   slave  : extension block; drives in_ready/out_valid/out_data/out_neg
interface imm_ext_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a 2-entry in-order result buffer.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_ext_if slave (in_valid/in_ready/in_imm/in_mode in,
//           out_valid/out_ready/out_data/out_neg out)
// Modes: 00 zero-extend, 01 sign-extend, 10 upper placement, 11 branch (sign << 2).
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  imm_ext_if.slave bus
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end
  endgenerate

  logic [OUT_W-1:0] data_q [2];
  logic [OUT_W-1:0] data_d [2];
  logic             neg_q  [2];
  logic             neg_d  [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic [OUT_W-1:0] sign_c;
  logic [OUT_W-1:0] ext_c;
  logic             push_c;
  logic             pop_c;

  // Extension datapath, evaluated on the incoming immediate
  always_comb begin
    sign_c = {{EXT_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext_c  = '0;
    unique case (bus.in_mode)
      2'b00:   ext_c = {{EXT_W{1'b0}}, bus.in_imm};
      2'b01:   ext_c = sign_c;
      2'b10:   ext_c = {bus.in_imm, {EXT_W{1'b0}}};
      default: ext_c = {sign_c[OUT_W-3:0], 2'b00};
    endcase
  end

  // Ready depends only on registered occupancy
  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = data_q[head_q];
  assign bus.out_neg   = neg_q[head_q];

  assign push_c = bus.in_valid & bus.in_ready;
  assign pop_c  = bus.out_valid & bus.out_ready;

  // Buffer next state
  always_comb begin
    data_d  = data_q;
    neg_d   = neg_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) begin
      data_d[tail_q] = ext_c;
      neg_d[tail_q]  = ext_c[OUT_W-1];
      tail_d         = ~tail_q;
    end
    if (pop_c) begin
      head_d = ~head_q;
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      neg_q[0]  <= 1'b0;
      neg_q[1]  <= 1'b0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      data_q  <= data_d;
      neg_q   <= neg_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
